rvb_bitcnt_arb: RTL and testbench

RVB_BITCNT_ARB -- requirements
Module: rvb_bitcnt_arb

---
 rtl/rvb_bitcnt_arb_if.sv | 34 +++
 rtl/rvb_bitcnt_arb.sv | 76 +++++++
 tb/tb_rvb_bitcnt_arb.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/rvb_bitcnt_arb_if.sv
// rvb_bitcnt_arb_if: requester, response and shared bit-count unit signals of rvb_bitcnt_arb.
// slave is the arbiter view, master is the surrounding environment view.
interface rvb_bitcnt_arb_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    logic                     req0_valid, req0_ready, req1_valid, req1_ready;
    logic [XLEN-1:0]          req0_rs1, req1_rs1;
    logic [3:0]               req0_insn, req1_insn;
    logic                     rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [XLEN-1:0]          rsp0_rd, rsp1_rd;
    logic                     unit_valid, unit_ready;
    logic [XLEN-1:0]          unit_rs1;
    logic                     unit_insn3, unit_insn20, unit_insn21, unit_insn22;
    logic                     unit_dout_valid, unit_dout_ready;
    logic [XLEN-1:0]          unit_rd;
    logic [$clog2(DEPTH):0]   inflight;
    logic                     err;

    modport slave (
        input  req0_valid, req0_rs1, req0_insn, req1_valid, req1_rs1, req1_insn,
               rsp0_ready, rsp1_ready, unit_ready, unit_dout_valid, unit_rd,
        output req0_ready, req1_ready, rsp0_valid, rsp0_rd, rsp1_valid, rsp1_rd,
               unit_valid, unit_rs1, unit_insn3, unit_insn20, unit_insn21, unit_insn22,
               unit_dout_ready, inflight, err
    );
    modport master (
        output req0_valid, req0_rs1, req0_insn, req1_valid, req1_rs1, req1_insn,
               rsp0_ready, rsp1_ready, unit_ready, unit_dout_valid, unit_rd,
        input  req0_ready, req1_ready, rsp0_valid, rsp0_rd, rsp1_valid, rsp1_rd,
               unit_valid, unit_rs1, unit_insn3, unit_insn20, unit_insn21, unit_insn22,
               unit_dout_ready, inflight, err
    );
endinterface

// File: rtl/rvb_bitcnt_arb.sv
// rvb_bitcnt_arb: two-requester arbiter for a shared bit-count unit with in-order response routing.
// Define RVB_BITCNT_ARB_RR_EN for round-robin arbitration; default is fixed priority (req0 wins).
module rvb_bitcnt_arb #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic              clock,
    input  logic              resetn,
    rvb_bitcnt_arb_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);

    logic          tag_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          err_q, hold_q, hold_gnt_q;
    logic          full, empty, arb_gnt, gnt, push, pop, head;
`ifdef RVB_BITCNT_ARB_RR_EN
    logic          last_q;
`endif

    always_comb begin
        full  = cnt_q == (AW+1)'(DEPTH);
        empty = cnt_q == '0;
`ifdef RVB_BITCNT_ARB_RR_EN
        arb_gnt = (bus.req0_valid & bus.req1_valid) ? !last_q : bus.req1_valid;
`else
        arb_gnt = bus.req1_valid & !bus.req0_valid;
`endif
        // A stalled request keeps its grant as long as that requester still holds valid
        gnt = (hold_q & (hold_gnt_q ? bus.req1_valid : bus.req0_valid)) ? hold_gnt_q : arb_gnt;
        bus.unit_valid = (bus.req0_valid | bus.req1_valid) & !full & resetn;
        bus.req0_ready = !gnt & bus.unit_ready & !full & resetn;
        bus.req1_ready = gnt & bus.unit_ready & !full & resetn;
        bus.unit_rs1 = gnt ? bus.req1_rs1 : bus.req0_rs1;
        {bus.unit_insn22, bus.unit_insn21, bus.unit_insn20, bus.unit_insn3} = gnt ? bus.req1_insn : bus.req0_insn;
        push = bus.unit_valid & bus.unit_ready;
        head = tag_q[rptr_q];
        bus.rsp0_valid = bus.unit_dout_valid & !empty & !head & resetn;
        bus.rsp1_valid = bus.unit_dout_valid & !empty & head & resetn;
        bus.rsp0_rd = head ? '0 : bus.unit_rd;
        bus.rsp1_rd = head ? bus.unit_rd : '0;
        bus.unit_dout_ready = !empty & (head ? bus.rsp1_ready : bus.rsp0_ready) & resetn;
        pop = bus.unit_dout_valid & bus.unit_dout_ready;
        cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        bus.inflight = cnt_q;
        bus.err = err_q;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            hold_q     <= 1'b0;
            hold_gnt_q <= 1'b0;
`ifdef RVB_BITCNT_ARB_RR_EN
            last_q     <= 1'b1;
`endif
        end else begin
            if (push) begin
                tag_q[wptr_q] <= gnt;
                wptr_q        <= wptr_q + AW'(1);
            end
            if (pop) rptr_q <= rptr_q + AW'(1);
            cnt_q      <= cnt_d;
            err_q      <= err_q | (bus.unit_dout_valid & empty);
            hold_q     <= bus.unit_valid & !bus.unit_ready;
            hold_gnt_q <= gnt;
`ifdef RVB_BITCNT_ARB_RR_EN
            if (push) last_q <= gnt;
`endif
        end
    end
endmodule

// File: tb/tb_rvb_bitcnt_arb.sv
// tb_rvb_bitcnt_arb: directed vector table plus multi-cycle sequences for rvb_bitcnt_arb.
// Expected grant order follows RVB_BITCNT_ARB_RR_EN when the bench is built with it.
module tb_rvb_bitcnt_arb;
    logic clock, resetn;
    int   total, bad;
    logic [3:0] exp_tags;

    rvb_bitcnt_arb_if #(.XLEN(32), .DEPTH(4)) bus ();
    rvb_bitcnt_arb #(.XLEN(32), .DEPTH(4)) dut (.clock(clock), .resetn(resetn), .bus(bus.slave));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        r0v, r1v, ur, dv;
        logic        uv, r0r, r1r;
        logic [31:0] rs1;
        logic [3:0]  insn;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs;
        bus.req0_valid = 0; bus.req1_valid = 0;
        bus.req0_rs1 = 32'hAAAA0000; bus.req1_rs1 = 32'h5555FFFF;
        bus.req0_insn = 4'b1010; bus.req1_insn = 4'b0101;
        bus.rsp0_ready = 0; bus.rsp1_ready = 0;
        bus.unit_ready = 0; bus.unit_dout_valid = 0; bus.unit_rd = '0;
    endtask

    task automatic do_reset;
        resetn = 0;
        tick();
        resetn = 1;
    endtask

    initial begin
        total = 0; bad = 0;
`ifdef RVB_BITCNT_ARB_RR_EN
        exp_tags = 4'b1010;
`else
        exp_tags = 4'b0000;
`endif
        vecs[0] = '{0, 0, 0, 0, 0, 0, 0, 32'hAAAA0000, 4'b1010};
        vecs[1] = '{1, 0, 1, 0, 1, 1, 0, 32'hAAAA0000, 4'b1010};
        vecs[2] = '{0, 1, 1, 0, 1, 0, 1, 32'h5555FFFF, 4'b0101};
        vecs[3] = '{1, 1, 1, 0, 1, 1, 0, 32'hAAAA0000, 4'b1010};
        vecs[4] = '{1, 1, 0, 0, 1, 0, 0, 32'hAAAA0000, 4'b1010};
        vecs[5] = '{0, 1, 0, 1, 1, 0, 0, 32'h5555FFFF, 4'b0101};
        clear_inputs();
        resetn = 0;
        tick();
        tick();
        resetn = 1;
        @(negedge clock);
        chk("rst_inflight", 64'(bus.inflight), 0);
        chk("rst_err", 64'(bus.err), 0);
        chk("rst_uv", 64'(bus.unit_valid), 0);
        tick();

        // Combinational paths with an empty FIFO; inputs drop before each edge so nothing is pushed
        for (int i = 0; i < 6; i++) begin
            bus.req0_valid = vecs[i].r0v; bus.req1_valid = vecs[i].r1v;
            bus.unit_ready = vecs[i].ur; bus.unit_dout_valid = vecs[i].dv;
            bus.rsp0_ready = 1; bus.rsp1_ready = 1;
            @(negedge clock);
            chk($sformatf("v%0d_uv", i), 64'(bus.unit_valid), 64'(vecs[i].uv));
            chk($sformatf("v%0d_r0rdy", i), 64'(bus.req0_ready), 64'(vecs[i].r0r));
            chk($sformatf("v%0d_r1rdy", i), 64'(bus.req1_ready), 64'(vecs[i].r1r));
            chk($sformatf("v%0d_rs1", i), 64'(bus.unit_rs1), 64'(vecs[i].rs1));
            chk($sformatf("v%0d_insn", i),
                64'({bus.unit_insn22, bus.unit_insn21, bus.unit_insn20, bus.unit_insn3}), 64'(vecs[i].insn));
            chk($sformatf("v%0d_rspv", i), 64'({bus.rsp0_valid, bus.rsp1_valid, bus.unit_dout_ready}), 0);
            clear_inputs();
            tick();
        end
        @(negedge clock);
        chk("v_inflight", 64'(bus.inflight), 0);
        tick();

        // Single issue round trip
        clear_inputs(); do_reset();
        bus.req0_valid = 1; bus.req0_rs1 = 32'h0000000F; bus.req0_insn = 4'b0000; bus.unit_ready = 1;
        @(negedge clock);
        chk("a_r0rdy", 64'(bus.req0_ready), 1);
        chk("a_rs1", 64'(bus.unit_rs1), 64'h0F);
        tick();
        bus.req0_valid = 0; bus.unit_ready = 0;
        bus.unit_dout_valid = 1; bus.unit_rd = 32'd4; bus.rsp0_ready = 1;
        @(negedge clock);
        chk("a_inflight1", 64'(bus.inflight), 1);
        chk("a_rsp0v", 64'(bus.rsp0_valid), 1);
        chk("a_rsp0rd", 64'(bus.rsp0_rd), 4);
        chk("a_rsp1v", 64'(bus.rsp1_valid), 0);
        chk("a_udr", 64'(bus.unit_dout_ready), 1);
        tick();
        bus.unit_dout_valid = 0;
        @(negedge clock);
        chk("a_inflight0", 64'(bus.inflight), 0);
        chk("a_err", 64'(bus.err), 0);

        // Conflict grants until full, one pop while full, then drain in order
        clear_inputs(); do_reset();
        bus.req0_valid = 1; bus.req1_valid = 1; bus.unit_ready = 1;
        bus.rsp0_ready = 1; bus.rsp1_ready = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk($sformatf("b_gnt1_%0d", i), 64'(bus.req1_ready), 64'(exp_tags[i]));
            chk($sformatf("b_gnt0_%0d", i), 64'(bus.req0_ready), 64'(!exp_tags[i]));
            tick();
        end
        @(negedge clock);
        chk("b_full_inflight", 64'(bus.inflight), 4);
        chk("b_full_uv", 64'(bus.unit_valid), 0);
        chk("b_full_rdy", 64'({bus.req0_ready, bus.req1_ready}), 0);
        tick();
        bus.unit_dout_valid = 1; bus.unit_rd = 32'h77;
        @(negedge clock);
        chk("b_pop_uv", 64'(bus.unit_valid), 0);
        chk("b_pop_rsp1v", 64'(bus.rsp1_valid), 64'(exp_tags[0]));
        chk("b_pop_rsp0v", 64'(bus.rsp0_valid), 64'(!exp_tags[0]));
        chk("b_pop_udr", 64'(bus.unit_dout_ready), 1);
        tick();
        bus.unit_ready = 0; bus.unit_dout_valid = 0;
        @(negedge clock);
        chk("b_after_inflight", 64'(bus.inflight), 3);
        chk("b_after_uv", 64'(bus.unit_valid), 1);
        tick();
        bus.req0_valid = 0; bus.req1_valid = 0; bus.unit_dout_valid = 1;
        for (int i = 1; i < 4; i++) begin
            @(negedge clock);
            chk($sformatf("b_drain1_%0d", i), 64'(bus.rsp1_valid), 64'(exp_tags[i]));
            chk($sformatf("b_drain0_%0d", i), 64'(bus.rsp0_valid), 64'(!exp_tags[i]));
            tick();
        end
        bus.unit_dout_valid = 0;
        @(negedge clock);
        chk("b_end_inflight", 64'(bus.inflight), 0);
        chk("b_end_err", 64'(bus.err), 0);

        // Per-requester ordering with head-of-line backpressure
        clear_inputs(); do_reset();
        bus.unit_ready = 1; bus.req1_valid = 1;
        @(negedge clock);
        chk("c_iss1", 64'(bus.req1_ready), 1);
        tick();
        bus.req1_valid = 0; bus.req0_valid = 1;
        @(negedge clock);
        chk("c_iss0", 64'(bus.req0_ready), 1);
        tick();
        bus.req0_valid = 0; bus.req1_valid = 1;
        tick();
        bus.req1_valid = 0; bus.unit_ready = 0;
        bus.unit_dout_valid = 1; bus.unit_rd = 32'h11; bus.rsp0_ready = 1; bus.rsp1_ready = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk($sformatf("c_bp_udr%0d", i), 64'(bus.unit_dout_ready), 0);
            chk($sformatf("c_bp_rsp0v%0d", i), 64'(bus.rsp0_valid), 0);
            chk($sformatf("c_bp_rsp1v%0d", i), 64'(bus.rsp1_valid), 1);
            chk($sformatf("c_bp_inflight%0d", i), 64'(bus.inflight), 3);
            tick();
        end
        bus.rsp1_ready = 1;
        @(negedge clock);
        chk("c_r1_v", 64'(bus.rsp1_valid), 1);
        chk("c_r1_rd", 64'(bus.rsp1_rd), 64'h11);
        chk("c_r1_udr", 64'(bus.unit_dout_ready), 1);
        tick();
        bus.unit_rd = 32'h22;
        @(negedge clock);
        chk("c_r2_v", 64'({bus.rsp0_valid, bus.rsp1_valid}), 64'b10);
        chk("c_r2_rd", 64'(bus.rsp0_rd), 64'h22);
        tick();
        bus.unit_rd = 32'h33;
        @(negedge clock);
        chk("c_r3_v", 64'({bus.rsp0_valid, bus.rsp1_valid}), 64'b01);
        chk("c_r3_rd", 64'(bus.rsp1_rd), 64'h33);
        tick();
        bus.unit_dout_valid = 0;
        @(negedge clock);
        chk("c_end_inflight", 64'(bus.inflight), 0);
        chk("c_end_err", 64'(bus.err), 0);

        // Reset while operations are in flight
        clear_inputs(); do_reset();
        bus.req0_valid = 1; bus.unit_ready = 1;
        tick(); tick(); tick();
        bus.req0_valid = 0;
        @(negedge clock);
        chk("d_inflight3", 64'(bus.inflight), 3);
        resetn = 0;
        bus.req0_valid = 1; bus.req1_valid = 1; bus.unit_dout_valid = 1;
        bus.rsp0_ready = 1; bus.rsp1_ready = 1;
        #1;
        chk("d_rst_outs", 64'({bus.unit_valid, bus.req0_ready, bus.req1_ready,
                               bus.rsp0_valid, bus.rsp1_valid, bus.unit_dout_ready}), 0);
        tick();
        resetn = 1; bus.unit_dout_valid = 0;
        @(negedge clock);
        chk("d_inflight0", 64'(bus.inflight), 0);
        chk("d_r0win", 64'({bus.req0_ready, bus.req1_ready}), 64'b10);
        tick();

        // Result with nothing outstanding sets the sticky error
        clear_inputs(); do_reset();
        bus.unit_dout_valid = 1; bus.unit_rd = 32'h5; bus.rsp0_ready = 1; bus.rsp1_ready = 1;
        @(negedge clock);
        chk("e_udr", 64'(bus.unit_dout_ready), 0);
        chk("e_err_pre", 64'(bus.err), 0);
        chk("e_rspv", 64'({bus.rsp0_valid, bus.rsp1_valid}), 0);
        tick();
        bus.unit_dout_valid = 0;
        @(negedge clock);
        chk("e_err_set", 64'(bus.err), 1);
        tick(); tick();
        @(negedge clock);
        chk("e_err_hold", 64'(bus.err), 1);
        tick();
        do_reset();
        @(negedge clock);
        chk("e_err_clr", 64'(bus.err), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
